// File: rtl/mem_stage_lsu.sv
// Memory pipeline stage: holds one instruction between execute and writeback,
// waits for load responses, extracts/extends load data and flags misaligned loads.
module mem_stage_lsu #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int RF_AW  = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_es_valid,
    output logic              o_ms_allowin,
    input  logic [PC_W-1:0]   i_es_pc,
    input  logic              i_es_reg_we,
    input  logic [RF_AW-1:0]  i_es_dest,
    input  logic [DATA_W-1:0] i_es_result,
    input  logic              i_es_load,
    input  logic [1:0]        i_es_load_size,
    input  logic              i_es_load_unsigned,
    input  logic              i_mem_rdata_valid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_ws_allowin,
    output logic              o_ms_to_ws_valid,
    output logic [PC_W-1:0]   o_ms_pc,
    output logic              o_ms_reg_we,
    output logic [RF_AW-1:0]  o_ms_dest,
    output logic [DATA_W-1:0] o_ms_final_result,
    output logic              o_ms_ale,
    output logic              o_ms_fwd_busy
);

    localparam int             LANE_W = $clog2(DATA_W / 8);
    localparam logic [7:0]     DW8    = 8'(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DRAIN} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_accept;
    logic                w_misaligned;
    logic [PC_W-1:0]     r_pc;
    logic                r_reg_we;
    logic [RF_AW-1:0]    r_dest;
    logic [DATA_W-1:0]   r_result;
    logic                r_ale;
    logic [LANE_W-1:0]   r_lane;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_top;
    logic [DATA_W-1:0]   w_ext;
    logic [7:0]          w_nbits;

    // A double-word access can never be naturally aligned on a 32-bit datapath.
    always_comb begin
        w_misaligned = 1'b0;
        case (i_es_load_size)
            2'd1:    w_misaligned = i_es_result[0];
            2'd2:    w_misaligned = |i_es_result[1:0];
            2'd3:    w_misaligned = (DATA_W == 32) || (|i_es_result[2:0]);
            default: w_misaligned = 1'b0;
        endcase
    end

    assign o_ms_allowin = (r_state == S_IDLE) || ((r_state == S_DONE) && i_ws_allowin);
    assign w_accept     = i_es_valid && o_ms_allowin && !i_flush;

    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = ((r_state == S_WAIT) && !i_mem_rdata_valid) ? S_DRAIN : S_IDLE;
        end else if (w_accept) begin
            w_state_next = (i_es_load && !w_misaligned) ? S_WAIT : S_DONE;
        end else begin
            case (r_state)
                S_WAIT:  if (i_mem_rdata_valid) w_state_next = S_DONE;
                S_DONE:  if (i_ws_allowin) w_state_next = S_IDLE;
                S_DRAIN: if (i_mem_rdata_valid) w_state_next = S_IDLE;
                default: w_state_next = r_state;
            endcase
        end
    end

    // Width-agnostic extraction: mask the selected lane, then fill above the top bit.
    always_comb begin
        w_shifted = i_mem_rdata >> {r_lane, 3'b000};
        w_nbits   = 8'd8 << r_size;
        if (w_nbits > DW8) begin
            w_nbits = DW8;
        end
        w_mask = {DATA_W{1'b1}} >> (DW8 - w_nbits);
        w_top  = w_mask & ~(w_mask >> 1);
        w_ext  = w_shifted & w_mask;
        if (!r_unsigned && (|(w_shifted & w_top))) begin
            w_ext = w_ext | ~w_mask;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_reg_we   <= 1'b0;
            r_dest     <= '0;
            r_result   <= '0;
            r_ale      <= 1'b0;
            r_lane     <= '0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_pc       <= i_es_pc;
                r_reg_we   <= i_es_reg_we && !(i_es_load && w_misaligned);
                r_dest     <= i_es_dest;
                r_result   <= i_es_result;
                r_ale      <= i_es_load && w_misaligned;
                r_lane     <= i_es_result[LANE_W-1:0];
                r_size     <= i_es_load_size;
                r_unsigned <= i_es_load_unsigned;
            end else if ((r_state == S_WAIT) && i_mem_rdata_valid && !i_flush) begin
                r_result <= w_ext;
            end
        end
    end

    assign o_ms_to_ws_valid  = (r_state == S_DONE);
    assign o_ms_fwd_busy     = (r_state == S_WAIT);
    assign o_ms_pc           = r_pc;
    assign o_ms_reg_we       = r_reg_we;
    assign o_ms_dest         = r_dest;
    assign o_ms_final_result = r_result;
    assign o_ms_ale          = r_ale;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: a 32-bit and a 64-bit instance driven by directed and
// randomized transactions, checked against a behavioural load/alignment model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  flush, es_valid, rvalid, ws_allowin;
    logic [31:0] es_pc;
    logic        es_reg_we;
    logic [4:0]  es_dest;
    logic [63:0] es_result;
    logic        es_load;
    logic [1:0]  es_size;
    logic        es_uns;
    logic [63:0] rdata;

    logic        a32, v32, we32, ale32, busy32;
    logic [31:0] pc32, res32;
    logic [4:0]  dest32;
    logic        a64, v64, we64, ale64, busy64;
    logic [31:0] pc64;
    logic [63:0] res64;
    logic [4:0]  dest64;

    int total = 0;
    int bad   = 0;
    logic [1:0] outstanding = 2'b00;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DATA_W(32), .PC_W(32), .RF_AW(5)) dut32 (
        .i_clk(clk), .i_reset(rst), .i_flush(flush[0]), .i_es_valid(es_valid[0]),
        .o_ms_allowin(a32), .i_es_pc(es_pc), .i_es_reg_we(es_reg_we), .i_es_dest(es_dest),
        .i_es_result(es_result[31:0]), .i_es_load(es_load), .i_es_load_size(es_size),
        .i_es_load_unsigned(es_uns), .i_mem_rdata_valid(rvalid[0]), .i_mem_rdata(rdata[31:0]),
        .i_ws_allowin(ws_allowin[0]), .o_ms_to_ws_valid(v32), .o_ms_pc(pc32),
        .o_ms_reg_we(we32), .o_ms_dest(dest32), .o_ms_final_result(res32),
        .o_ms_ale(ale32), .o_ms_fwd_busy(busy32)
    );

    mem_stage_lsu #(.DATA_W(64), .PC_W(32), .RF_AW(5)) dut64 (
        .i_clk(clk), .i_reset(rst), .i_flush(flush[1]), .i_es_valid(es_valid[1]),
        .o_ms_allowin(a64), .i_es_pc(es_pc), .i_es_reg_we(es_reg_we), .i_es_dest(es_dest),
        .i_es_result(es_result), .i_es_load(es_load), .i_es_load_size(es_size),
        .i_es_load_unsigned(es_uns), .i_mem_rdata_valid(rvalid[1]), .i_mem_rdata(rdata),
        .i_ws_allowin(ws_allowin[1]), .o_ms_to_ws_valid(v64), .o_ms_pc(pc64),
        .o_ms_reg_we(we64), .o_ms_dest(dest64), .o_ms_final_result(res64),
        .o_ms_ale(ale64), .o_ms_fwd_busy(busy64)
    );

    // Responses may only be driven while the bench itself has a load outstanding.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rvalid[d]) begin
                assert (outstanding[d]) else $error("protocol: response with no outstanding load, dut %0d", d);
            end
        end
    end

    // Reference model: pure arithmetic on address, size and data.
    function automatic logic [63:0] ref_load(int w, logic [63:0] addr, logic [63:0] data,
                                             int size, bit uns);
        logic [127:0] v;
        int lane, n;
        lane = int'(addr % 64'(w / 8));
        n    = 8 << size;
        if (n > w) n = w;
        v = {64'b0, data};
        if (w == 32) v[63:32] = '0;
        v = (v >> (8 * lane)) & ((128'd1 << n) - 128'd1);
        if (!uns && v[n-1]) v = v - (128'd1 << n);
        if (w == 32) v[63:32] = '0;
        return v[63:0];
    endfunction

    function automatic bit ref_mis(int w, logic [63:0] addr, int size);
        return (size == 3 && w == 32) || ((addr % (64'd1 << size)) != 64'd0);
    endfunction

    function automatic logic [63:0] fit(int w, logic [63:0] x);
        return (w == 32) ? {32'h0, x[31:0]} : x;
    endfunction

    function automatic logic [63:0] g_res(int d);  return (d != 0) ? res64 : {32'h0, res32}; endfunction
    function automatic logic [31:0] g_pc(int d);   return (d != 0) ? pc64 : pc32;            endfunction
    function automatic logic [4:0]  g_dest(int d); return (d != 0) ? dest64 : dest32;        endfunction
    function automatic logic        g_a(int d);    return (d != 0) ? a64 : a32;              endfunction
    function automatic logic        g_v(int d);    return (d != 0) ? v64 : v32;              endfunction
    function automatic logic        g_we(int d);   return (d != 0) ? we64 : we32;            endfunction
    function automatic logic        g_ale(int d);  return (d != 0) ? ale64 : ale32;          endfunction
    function automatic logic        g_busy(int d); return (d != 0) ? busy64 : busy32;        endfunction

    task automatic chk(string tag, int d, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%h required=%h", tag, (d != 0) ? 64 : 32, obs, exp);
        end
    endtask

    task automatic check_ctl(string tag, int d, bit v, bit a, bit b);
        chk({tag, "_valid"}, d, 64'(g_v(d)), 64'(v));
        chk({tag, "_allowin"}, d, 64'(g_a(d)), 64'(a));
        chk({tag, "_busy"}, d, 64'(g_busy(d)), 64'(b));
    endtask

    task automatic check_pay(string tag, int d, logic [31:0] pc, bit we, logic [4:0] dest,
                             logic [63:0] res, bit ale);
        chk({tag, "_pc"}, d, 64'(g_pc(d)), 64'(pc));
        chk({tag, "_we"}, d, 64'(g_we(d)), 64'(we));
        chk({tag, "_dest"}, d, 64'(g_dest(d)), 64'(dest));
        chk({tag, "_result"}, d, g_res(d), res);
        chk({tag, "_ale"}, d, 64'(g_ale(d)), 64'(ale));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction: accept, optional memory wait, bp stalled cycles, then ws_allowin=1
    // is left high so the caller's next accept completes the handshake back-to-back.
    task automatic run_txn(int d, bit load, logic [63:0] addr, logic [1:0] size, bit uns,
                           logic [63:0] data, int lat, int bp);
        int          w;
        bit          mis;
        logic [63:0] exp;
        logic [31:0] pc;
        logic [4:0]  dest;
        bit          we;
        w    = (d != 0) ? 64 : 32;
        mis  = load && ref_mis(w, addr, int'(size));
        exp  = (load && !mis) ? ref_load(w, addr, data, int'(size), uns) : fit(w, addr);
        pc   = $urandom;
        dest = 5'($urandom);
        we   = 1'($urandom);
        es_pc = pc; es_dest = dest; es_reg_we = we; es_result = addr;
        es_load = load; es_size = size; es_uns = uns;
        es_valid[d] = 1'b1;
        ws_allowin[d] = 1'b1;
        #1;
        chk("accept_allowin", d, 64'(g_a(d)), 64'd1);
        tick();
        es_valid[d] = 1'b0;
        if (load && !mis) begin
            outstanding[d] = 1'b1;
            for (int i = 1; i <= lat; i++) begin
                if (i == lat) begin
                    rvalid[d] = 1'b1;
                    rdata = data;
                end
                check_ctl("wait", d, 1'b0, 1'b0, 1'b1);
                tick();
            end
            rvalid[d] = 1'b0;
            outstanding[d] = 1'b0;
        end
        ws_allowin[d] = 1'b0;
        for (int i = 0; i < bp; i++) begin
            #1;
            check_ctl("stall", d, 1'b1, 1'b0, 1'b0);
            check_pay("stall", d, pc, we && !mis, dest, exp, mis);
            tick();
        end
        ws_allowin[d] = 1'b1;
        #1;
        check_ctl("done", d, 1'b1, 1'b1, 1'b0);
        check_pay("done", d, pc, we && !mis, dest, exp, mis);
        $display("txn dut%0d load=%0d addr=%h size=%0d uns=%0d lat=%0d bp=%0d exp=%h", w, load,
                 addr, size, uns, lat, bp, exp);
    endtask

    task automatic idle(int d, int n);
        es_valid[d] = 1'b0;
        ws_allowin[d] = 1'b1;
        repeat (n) tick();
        #1;
        check_ctl("idle", d, 1'b0, 1'b1, 1'b0);
    endtask

    // Load flushed in WAIT; response either two cycles later or in the flush cycle itself.
    task automatic flush_wait(int d, bit coincident);
        es_result = 64'h100; es_load = 1'b1; es_size = 2'd2; es_uns = 1'b0;
        es_valid[d] = 1'b1;
        ws_allowin[d] = 1'b1;
        #1;
        chk("flush_accept", d, 64'(g_a(d)), 64'd1);
        tick();
        es_valid[d] = 1'b0;
        outstanding[d] = 1'b1;
        flush[d] = 1'b1;
        rvalid[d] = coincident;
        rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        flush[d] = 1'b0;
        rvalid[d] = 1'b0;
        if (coincident) begin
            outstanding[d] = 1'b0;
            check_ctl("flush_coinc", d, 1'b0, 1'b1, 1'b0);
        end else begin
            check_ctl("drain1", d, 1'b0, 1'b0, 1'b0);
            tick();
            rvalid[d] = 1'b1;
            check_ctl("drain2", d, 1'b0, 1'b0, 1'b0);
            tick();
            rvalid[d] = 1'b0;
            outstanding[d] = 1'b0;
            check_ctl("drained", d, 1'b0, 1'b1, 1'b0);
            tick();
            check_ctl("drained_hold", d, 1'b0, 1'b1, 1'b0);
        end
        $display("flush dut%0d coincident=%0d", (d != 0) ? 64 : 32, coincident);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [1:0]  sz;
        int          d;
        rst = 1'b1;
        flush = '0; es_valid = '0; rvalid = '0; ws_allowin = 2'b11;
        es_pc = '0; es_reg_we = 1'b0; es_dest = '0; es_result = '0;
        es_load = 1'b0; es_size = '0; es_uns = 1'b0; rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_ctl("reset", k, 1'b0, 1'b1, 1'b0);
            check_pay("reset", k, 32'h0, 1'b0, 5'h0, 64'h0, 1'b0);
        end
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) run_txn(0, 1'b0, 64'h1234_5678, 2'd0, 1'b0, 64'h0, 0, 0);
        run_txn(0, 1'b1, 64'h1000_0003, 2'd0, 1'b0, 64'h80FF_0000, 3, 0);
        run_txn(0, 1'b1, 64'h1000_0003, 2'd0, 1'b1, 64'h80FF_0000, 3, 0);
        run_txn(0, 1'b1, 64'h1000_0001, 2'd1, 1'b0, 64'h0, 0, 0);
        run_txn(0, 1'b1, 64'h0000_0000, 2'd3, 1'b0, 64'h0, 0, 0);
        run_txn(0, 1'b1, 64'h2000_0002, 2'd1, 1'b0, 64'h0000_8001, 1, 5);
        run_txn(0, 1'b0, 64'hCAFE_F00D, 2'd0, 1'b0, 64'h0, 0, 0);
        idle(0, 2);
        flush_wait(0, 1'b0);
        flush_wait(0, 1'b1);

        run_txn(1, 1'b1, 64'h3000_0004, 2'd2, 1'b1, 64'hDEAD_BEEF_0000_0001, 2, 0);
        run_txn(1, 1'b1, 64'h3000_0000, 2'd3, 1'b0, 64'h8877_6655_4433_2211, 1, 1);
        run_txn(1, 1'b1, 64'h3000_0006, 2'd1, 1'b0, 64'h8001_0000_0000_0000, 4, 0);
        flush_wait(1, 1'b0);

        for (int i = 0; i < 80; i++) begin
            d  = int'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            sz = 2'($urandom);
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            run_txn(d, 1'($urandom_range(0, 3) != 0), a, sz, 1'($urandom), {$urandom, $urandom},
                    int'($urandom_range(1, 4)), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0) idle(d, int'($urandom_range(1, 2)));
        end

        // Flush in DONE discards the result and blocks a simultaneous accept.
        run_txn(0, 1'b0, 64'h5555_AAAA, 2'd0, 1'b0, 64'h0, 0, 0);
        flush[0] = 1'b1;
        es_valid[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        es_valid[0] = 1'b0;
        check_ctl("flush_done", 0, 1'b0, 1'b1, 1'b0);
        $display("flush in done dut32");

        // Asynchronous reset while a load waits.
        es_result = 64'h40; es_load = 1'b1; es_size = 2'd2; es_uns = 1'b1;
        es_valid[1] = 1'b1;
        ws_allowin[1] = 1'b1;
        tick();
        es_valid[1] = 1'b0;
        outstanding[1] = 1'b1;
        check_ctl("pre_reset", 1, 1'b0, 1'b0, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check_ctl("async_reset", 1, 1'b0, 1'b1, 1'b0);
        check_pay("async_reset", 1, 32'h0, 1'b0, 5'h0, 64'h0, 1'b0);
        #1;
        rst = 1'b0;
        outstanding[1] = 1'b0;
        $display("async reset during wait dut64");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor to the memory pipeline stage; sits between the execute and writeback stages.
- Holds one instruction under a valid/allowin handshake.
- For loads, waits a variable number of cycles for the data-memory response, then performs byte/half/word/double extraction with sign or zero extension.
- Detects misaligned loads, drops responses orphaned by a flush, and exposes forwarding status to execute.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- PC_W, 32, width of the PC carried through the stage.
- RF_AW, 5, register-file address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  exception/redirect flush; kills the held instruction
- es_valid  in  1  execute stage presents an instruction
- ms_allowin  out  1  stage can accept this cycle
- es_pc  in  PC_W  instruction PC
- es_reg_we  in  1  instruction writes the register file
- es_dest  in  RF_AW  destination register
- es_result  in  DATA_W  ALU result; effective address for loads
- es_load  in  1  instruction is a load
- es_load_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- es_load_unsigned  in  1  zero-extend instead of sign-extend
- mem_rdata_valid  in  1  load response valid (single-cycle pulse)
- mem_rdata  in  DATA_W  load response data, aligned to the containing DATA_W word
- ws_allowin  in  1  writeback can accept
- ms_to_ws_valid  out  1  result valid toward writeback
- ms_pc  out  PC_W  PC of the held instruction
- ms_reg_we  out  1  write-enable; forced 0 when ms_ale = 1
- ms_dest  out  RF_AW  destination register
- ms_final_result  out  DATA_W  writeback data
- ms_ale  out  1  address-misaligned exception flag for the held instruction
- ms_fwd_busy  out  1  held load whose data has not yet returned; execute must stall dependents

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; all output registers 0; ms_allowin = 1.
- State machine:
  - IDLE: empty.
  - WAIT: load issued, awaiting response.
  - DONE: result ready.
  - DRAIN: flushed load whose response is still outstanding.
- Accept condition: es_valid && ms_allowin. ms_allowin = (state == IDLE) || (state == DONE && ws_allowin).
- Non-load accept: ms_final_result = es_result; next state DONE. Accepted in cycle N gives ms_to_ws_valid in cycle N+1.
- Load accept, aligned: next state WAIT; ms_fwd_busy = 1.
- Alignment is checked on the low address bits:
  - half requires addr[0] = 0
  - word requires addr[1:0] = 0
  - double requires addr[2:0] = 0
  - size 3 with DATA_W = 32 is always treated as misaligned.
- Load accept, misaligned: next state DONE directly; ms_ale = 1, ms_reg_we = 0, ms_final_result = es_result (bad VA); no memory wait.
- WAIT with mem_rdata_valid:
  - Byte lane = addr[log2(DATA_W/8)-1:0].
  - Extract size bits at that lane, extend per es_load_unsigned, register into ms_final_result.
  - Next state DONE. Response in cycle M gives ms_to_ws_valid in cycle M+1.
  - A response arriving in the same cycle as acceptance is not legal; the earliest legal response is the cycle after acceptance.
- ms_to_ws_valid = (state == DONE). Handshake completes when DONE && ws_allowin. A new accept in the same cycle goes back-to-back; otherwise the next state is IDLE.
- DONE with ws_allowin = 0: all outputs are held stable for any number of cycles.
- mem_rdata_valid in IDLE or DONE: ignored. This is a protocol error, and the bench asserts it never occurs.
- flush, highest priority, takes effect the same cycle:
  - From WAIT: go to DRAIN, unless mem_rdata_valid is also high that cycle, in which case go to IDLE.
  - From any other state: go to IDLE.
  - No accept is taken in a flush cycle.
- DRAIN: ms_allowin = 0, ms_to_ws_valid = 0, ms_fwd_busy = 0. The next mem_rdata_valid is consumed and discarded; then go to IDLE.
- At most one outstanding load at any time.

Test Plan:
- Non-load: es_result 0x1234_5678, ws_allowin = 1 -> ms_to_ws_valid one cycle later, ms_final_result = 0x1234_5678, ms_allowin stays 1 (back-to-back stream of 4 at full rate).
- Signed byte load at addr 0x...03, mem_rdata 0x80FF_0000 returned 3 cycles after accept -> ms_fwd_busy high for 3 cycles, then ms_final_result = 0xFFFF_FF80; unsigned variant -> 0x0000_0080.
- Half load at addr 0x...01 -> next cycle ms_ale = 1, ms_reg_we = 0, ms_final_result = addr, no memory wait; DATA_W = 32 with size 3 at addr 0 -> ms_ale = 1.
- Backpressure: load completes with ws_allowin = 0 for 5 cycles -> outputs constant, ms_allowin = 0; ws_allowin rises -> handshake, new instruction accepted the same cycle.
- flush while in WAIT, response arrives 2 cycles later -> no ms_to_ws_valid, ms_allowin = 0 until the response cycle, then 1; flush coincident with the response -> IDLE immediately.
- DATA_W = 64: unsigned word load at addr 0x...04, mem_rdata 0xDEAD_BEEF_0000_0001 -> ms_final_result = 0x0000_0000_DEAD_BEEF; assert reset mid-WAIT -> all outputs 0 asynchronously.
